// File: rtl/dma_csr_responder.sv
// rtl/dma_csr_responder.sv - DMA CSR register block with beat-level transfer engine
module dma_csr_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BEAT_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  xfer_req,
    output logic [DATA_WIDTH-1:0] xfer_src,
    output logic [DATA_WIDTH-1:0] xfer_dst,
    input  logic                  xfer_ack,
    output logic                  irq
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] A_SRC    = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] A_DST    = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] A_LEN    = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] A_CNT    = ADDR_WIDTH'(8'h14);

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'(BEAT_BYTES - 1);
    localparam logic [DATA_WIDTH-1:0] BEAT_INC   = DATA_WIDTH'(BEAT_BYTES);
    localparam logic [15:0]           BEAT16     = 16'(BEAT_BYTES);

    state_t                state_q, state_d;
    logic                  int_en_q, int_en_d;
    logic [DATA_WIDTH-1:0] src_q, src_d;
    logic [DATA_WIDTH-1:0] dst_q, dst_d;
    logic [15:0]           len_q, len_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [15:0]           rem_q, rem_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] cur_src_q, cur_src_d;
    logic [DATA_WIDTH-1:0] cur_dst_q, cur_dst_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  busy, beat, last_beat, start_req, abort_req, misaligned;
    logic                  wr_ctrl, wr_stat, set_done, set_err;
    logic [DATA_WIDTH-1:0] rd_val;

    always_comb begin
        state_d   = state_q;
        int_en_d  = int_en_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        set_done  = 1'b0;
        set_err   = 1'b0;
        last_beat = 1'b0;

        busy       = (state_q == ST_RUN);
        beat       = busy && xfer_ack;
        wr_ctrl    = wr_en && (addr == A_CTRL);
        wr_stat    = wr_en && (addr == A_STATUS);
        start_req  = wr_ctrl && wdata[0] && !busy;
        abort_req  = wr_ctrl && wdata[2] && busy;
        misaligned = ((src_q & ALIGN_MASK) != '0) || ((dst_q & ALIGN_MASK) != '0);

        // An ack coincident with ABORT still retires its beat before the engine stops
        if (beat) begin
            if (rem_q > BEAT16) begin
                rem_d = rem_q - BEAT16;
            end else begin
                rem_d     = 16'd0;
                last_beat = 1'b1;
            end
            cur_src_d = cur_src_q + BEAT_INC;
            cur_dst_d = cur_dst_q + BEAT_INC;
        end

        if (abort_req) begin
            state_d = ST_IDLE;
            set_err = 1'b1;
        end else if (last_beat) begin
            state_d  = ST_IDLE;
            set_done = 1'b1;
            cnt_d    = cnt_q + 1'b1;
        end

        if (start_req) begin
            if (len_q == 16'd0 || misaligned) begin
                set_err = 1'b1;
            end else begin
                state_d   = ST_RUN;
                rem_d     = len_q;
                cur_src_d = src_q;
                cur_dst_d = dst_q;
            end
        end

        if (wr_ctrl) int_en_d = wdata[1];
        if (wr_en && !busy && addr == A_SRC) src_d = wdata;
        if (wr_en && !busy && addr == A_DST) dst_d = wdata;
        if (wr_en && !busy && addr == A_LEN) len_d = wdata[15:0];

        // Engine set wins over a same-cycle W1C
        done_d = (done_q & ~(wr_stat & wdata[1])) | set_done;
        err_d  = (err_q  & ~(wr_stat & wdata[2])) | set_err;

        case (addr)
            A_CTRL:   rd_val = DATA_WIDTH'({int_en_q, 1'b0});
            A_SRC:    rd_val = src_q;
            A_DST:    rd_val = dst_q;
            A_LEN:    rd_val = DATA_WIDTH'(len_q);
            A_STATUS: rd_val = DATA_WIDTH'({rem_q, 13'd0, err_q, done_q, busy});
            A_CNT:    rd_val = cnt_q;
            default:  rd_val = '0;
        endcase
        rdata_d = rd_en ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            int_en_q  <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rem_q     <= '0;
            cnt_q     <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            int_en_q  <= int_en_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata    = rdata_q;
    assign xfer_req = (state_q == ST_RUN);
    assign xfer_src = cur_src_q;
    assign xfer_dst = cur_dst_q;
    assign irq      = int_en_q & (done_q | err_q);

endmodule

// File: tb/tb_dma_csr_responder.sv
// tb/tb_dma_csr_responder.sv - randomized bench for dma_csr_responder against a beat-queue model
module tb_dma_csr_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en, xfer_ack;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata, xfer_src, xfer_dst;
    logic        xfer_req, irq;

    dma_csr_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BEAT_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
        .addr(addr), .rdata(rdata), .xfer_req(xfer_req), .xfer_src(xfer_src),
        .xfer_dst(xfer_dst), .xfer_ack(xfer_ack), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: register values plus the list of beats still to be issued for the active transfer
    bit          m_int_en, m_done, m_err;
    logic [31:0] m_src, m_dst, m_cnt, m_rdata;
    logic [15:0] m_len, m_rem;
    logic [31:0] q_src[$];
    logic [31:0] q_dst[$];

    function automatic void model_reset();
        m_int_en = 0; m_done = 0; m_err = 0;
        m_src = 0; m_dst = 0; m_cnt = 0; m_rdata = 0;
        m_len = 0; m_rem = 0;
        q_src.delete(); q_dst.delete();
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return {30'd0, m_int_en, 1'b0};
            8'h04:   return m_src;
            8'h08:   return m_dst;
            8'h0C:   return {16'd0, m_len};
            8'h10:   return {m_rem, 13'd0, m_err, m_done, q_src.size() != 0};
            8'h14:   return m_cnt;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step(input logic w, input logic r, input logic [7:0] a,
                                       input logic [31:0] d, input logic k);
        bit busy, ab, st, set_d, set_e;
        busy  = q_src.size() != 0;
        set_d = 0;
        set_e = 0;
        if (r) m_rdata = m_read(a);
        ab = w && a == 8'h00 && d[2] && busy;
        st = w && a == 8'h00 && d[0] && !busy;
        if (busy && k) begin
            void'(q_src.pop_front());
            void'(q_dst.pop_front());
            m_rem = (m_rem > 16'd4) ? 16'(m_rem - 16'd4) : 16'd0;
            if (q_src.size() == 0 && !ab) begin
                set_d = 1;
                m_cnt = m_cnt + 1;
            end
        end
        if (ab) begin
            q_src.delete();
            q_dst.delete();
            set_e = 1;
        end
        if (st) begin
            if (m_len == 0 || m_src[1:0] != 0 || m_dst[1:0] != 0) begin
                set_e = 1;
            end else begin
                m_rem = m_len;
                for (int i = 0; i < (int'(m_len) + 3) / 4; i++) begin
                    q_src.push_back(m_src + 32'(4 * i));
                    q_dst.push_back(m_dst + 32'(4 * i));
                end
            end
        end
        if (w) begin
            case (a)
                8'h00: m_int_en = d[1];
                8'h04: if (!busy) m_src = d;
                8'h08: if (!busy) m_dst = d;
                8'h0C: if (!busy) m_len = d[15:0];
                8'h10: begin
                    if (d[1]) m_done = 0;
                    if (d[2]) m_err = 0;
                end
                default: ;
            endcase
        end
        m_done = m_done | set_d;
        m_err  = m_err | set_e;
    endfunction

    task automatic compare_outputs();
        bit busy;
        busy = q_src.size() != 0;
        check("xfer_req", 32'(xfer_req), 32'(busy));
        if (busy) begin
            check("xfer_src", xfer_src, q_src[0]);
            check("xfer_dst", xfer_dst, q_dst[0]);
        end
        check("irq", 32'(irq), 32'(m_int_en & (m_done | m_err)));
        check("rdata", rdata, m_rdata);
    endtask

    // Called at a negedge: drive inputs, advance the model, then sample at the next negedge
    task automatic cyc(input logic w, input logic r, input logic [7:0] a,
                       input logic [31:0] d, input logic k);
        wr_en = w; rd_en = r; addr = a; wdata = d; xfer_ack = k;
        model_step(w, r, a, d, k);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        cyc(1'b0, 1'b1, a, 32'd0, 1'b0);
        check(tag, rdata, exp);
    endtask

    logic [7:0] addrs[8];
    logic [7:0] ra;
    logic [31:0] rd32;
    int op;

    initial begin
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20};
        rst_n = 1'b0; wr_en = 0; rd_en = 0; addr = 0; wdata = 0; xfer_ack = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        compare_outputs();

        for (int i = 0; i < 6; i++) rd_chk("reset_reg", 8'(4 * i), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_req", 32'(xfer_req), 32'd0);

        wr(8'h04, 32'h1000); wr(8'h08, 32'h2000); wr(8'h0C, 32'h10);
        rd_chk("rb_src", 8'h04, 32'h1000);
        rd_chk("rb_dst", 8'h08, 32'h2000);
        rd_chk("rb_len", 8'h0C, 32'h10);
        rd_chk("rb_unmapped", 8'h20, 32'd0);

        cyc(1'b1, 1'b0, 8'h00, 32'h3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("beat_src", xfer_src, 32'h1000 + 32'(4 * i));
            check("beat_dst", xfer_dst, 32'h2000 + 32'(4 * i));
            cyc(1'b0, 1'b0, 8'h00, 32'd0, 1'b1);
        end
        check("done_req", 32'(xfer_req), 32'd0);
        rd_chk("done_status", 8'h10, 32'h0000_0002);
        rd_chk("done_cnt", 8'h14, 32'd1);
        check("done_irq", 32'(irq), 32'd1);
        wr(8'h10, 32'h2);
        check("w1c_irq", 32'(irq), 32'd0);

        wr(8'h0C, 32'd6);
        cyc(1'b1, 1'b0, 8'h00, 32'h3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_src", xfer_src, 32'h1000);
            cyc(1'b0, 1'b0, 8'h00, 32'd0, 1'b0);
        end
        cyc(1'b0, 1'b1, 8'h10, 32'd0, 1'b1);
        check("rem6", rdata, 32'h0006_0001);
        cyc(1'b0, 1'b1, 8'h10, 32'd0, 1'b1);
        check("rem2", rdata, 32'h0002_0001);
        check("partial_req", 32'(xfer_req), 32'd0);
        rd_chk("partial_status", 8'h10, 32'h0000_0002);
        wr(8'h10, 32'h2);

        wr(8'h04, 32'h1002);
        wr(8'h00, 32'h3);
        check("misalign_req", 32'(xfer_req), 32'd0);
        rd_chk("misalign_status", 8'h10, 32'h0000_0004);
        wr(8'h10, 32'h4);
        wr(8'h04, 32'h1000); wr(8'h0C, 32'h40);
        wr(8'h00, 32'h3);
        cyc(1'b0, 1'b0, 8'h00, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 32'd0, 1'b1);
        wr(8'h00, 32'h6);
        check("abort_req", 32'(xfer_req), 32'd0);
        rd_chk("abort_status", 8'h10, 32'h0038_0004);
        rd_chk("abort_cnt", 8'h14, 32'd2);
        wr(8'h10, 32'h4);

        wr(8'h00, 32'h3);
        wr(8'h0C, 32'h100);
        rd_chk("busy_len", 8'h0C, 32'h40);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req", 32'(xfer_req), 32'd0);
        check("rst_src", xfer_src, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) rd_chk("rst_reg", 8'(4 * i), 32'd0);

        for (int n = 0; n < 600; n++) begin
            op   = $urandom_range(0, 9);
            ra   = addrs[$urandom_range(0, 7)];
            rd32 = $urandom;
            case (op)
                0, 1, 2: cyc(1'b1, $urandom_range(0, 3) == 0, 8'h00, 32'($urandom_range(0, 7)),
                             $urandom_range(0, 2) != 0);
                3: begin
                    if ($urandom_range(0, 5) == 0) rd32 = 32'hFFFF_FFF0;
                    else if ($urandom_range(0, 5) != 0) rd32 = rd32 & ~32'h3;
                    cyc(1'b1, $urandom_range(0, 1) == 0, ($urandom_range(0, 1) != 0) ? 8'h04 : 8'h08,
                        rd32, $urandom_range(0, 2) != 0);
                end
                4: cyc(1'b1, 1'b0, 8'h0C, (rd32 & 32'hFFFF_0000) | 32'($urandom_range(0, 40)),
                       $urandom_range(0, 2) != 0);
                5: cyc(1'b1, $urandom_range(0, 1) == 0, 8'h10, rd32, $urandom_range(0, 2) != 0);
                default: cyc($urandom_range(0, 4) == 0, 1'b1, ra, rd32, $urandom_range(0, 2) != 0);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_csr_responder.md
Name: dma_csr_responder

Overview:
- Register-side responder for the DMA CSR bus (wr_en/rd_en/wdata/addr/rdata) that the verification environment drives.
- Holds the DMA control and status registers and returns registered read data.
- Runs a beat-level transfer engine that issues src/dst beat requests over a valid/ack handshake toward the memory side.
- Drives the interrupt line.

Parameters:
- DATA_WIDTH, 32, CSR data width; register fields below assume 32.
- ADDR_WIDTH, 8, CSR byte-address width.
- BEAT_BYTES, 4, bytes moved per accepted beat; must be a power of 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  CSR write strobe; write takes effect on the same posedge.
- rd_en  in  1  CSR read strobe.
- wdata  in  DATA_WIDTH  CSR write data.
- addr  in  ADDR_WIDTH  CSR byte address.
- rdata  out  DATA_WIDTH  CSR read data, registered.
- xfer_req  out  1  beat request valid.
- xfer_src  out  DATA_WIDTH  current beat source address.
- xfer_dst  out  DATA_WIDTH  current beat destination address.
- xfer_ack  in  1  beat accepted by memory side.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async, rst_n=0): all registers 0, FSM=IDLE, rdata=0, xfer_req=0, xfer_src=0, xfer_dst=0, irq=0.
- Register map (byte addresses):
  - 0x00 CTRL: [0] START (write-1 pulse, reads 0); [1] INT_EN (RW); [2] ABORT (write-1 pulse, reads 0).
  - 0x04 SRC (RW).
  - 0x08 DST (RW).
  - 0x0C LEN (RW): [15:0] byte count; upper bits read 0.
  - 0x10 STATUS: [0] BUSY (RO); [1] DONE (W1C); [2] ERR (W1C); [31:16] REMAINING bytes (RO).
  - 0x14 XFER_CNT (RO): count of completed transfers; wraps at 2^32.
  - Unmapped addresses: reads return 0; writes are ignored.
- Read timing: rdata updates at the posedge where rd_en=1, so data is visible the cycle after rd_en. rdata holds its value while rd_en=0.
- Simultaneous wr_en and rd_en at the same addr: read returns the pre-write value; the write still commits.
- Writes to SRC, DST or LEN while BUSY=1 are ignored. Writes to CTRL.INT_EN are always accepted.
- FSM states: IDLE, RUN.
- START in IDLE:
  - If LEN==0, or SRC or DST is not BEAT_BYTES-aligned: set ERR; stay IDLE.
  - Otherwise: next cycle enter RUN.
    - BUSY=1.
    - REMAINING=LEN; cur_src=SRC; cur_dst=DST.
    - xfer_req=1 with xfer_src=cur_src and xfer_dst=cur_dst.
- START while in RUN is ignored.
- RUN:
  - A beat completes on a posedge where xfer_req && xfer_ack.
  - On each completed beat:
    - REMAINING -= min(REMAINING, BEAT_BYTES).
    - cur_src += BEAT_BYTES; cur_dst += BEAT_BYTES.
  - xfer_req stays 1 and addresses stay stable until ack. A partial final beat (LEN not a multiple of BEAT_BYTES) counts as one beat.
- Completion: on the beat that takes REMAINING to 0:
  - Next cycle: IDLE, xfer_req=0, BUSY=0.
  - DONE=1.
  - XFER_CNT+1.
- ABORT in RUN:
  - Next cycle: IDLE, xfer_req=0, ERR=1.
  - DONE and XFER_CNT unchanged; REMAINING holds its residual value.
  - An ack in the same cycle as the ABORT write is still counted as a beat.
- ABORT in IDLE: no effect.
- Address arithmetic wraps modulo 2^DATA_WIDTH.
- irq = INT_EN & (DONE | ERR). Combinational from registered bits, so irq has no extra latency.
- W1C of DONE or ERR in the same cycle the engine sets that bit: the set wins.
- START and ABORT in the same write: ABORT is applied. If IDLE, START is evaluated and ABORT is ignored.
- Reset mid-RUN: immediate return to reset values; no further beats are issued.

Test Plan:
1. Reset defaults: after reset, read each of 0x00–0x14 → each read returns 0; irq=0; xfer_req=0.
2. Register access and readback:
   - Write SRC=0x1000, DST=0x2000, LEN=0x10.
   - Read back → 0x1000, 0x2000, 0x10; rdata valid one cycle after rd_en.
   - Read 0x20 → 0.
3. Normal transfer:
   - Setup as in 2; INT_EN=1; START; xfer_ack tied 1.
   - Beats: (0x1000,0x2000), (0x1004,0x2004), (0x1008,0x2008), (0x100C,0x200C).
   - Then STATUS=0x0000_0002, XFER_CNT=1, irq=1.
   - W1C 0x2 to STATUS → irq=0.
4. Backpressure and partial beat:
   - LEN=6; xfer_ack low for 3 cycles, then high.
   - xfer_src held at 0x1000 while ack is low.
   - Exactly 2 beats issue; REMAINING goes 6→2→0.
5. Error and abort:
   - SRC=0x1002, START → ERR=1, no xfer_req.
   - Valid setup with LEN=0x40; ABORT after 2 acked beats → ERR=1, DONE=0, REMAINING=0x38, xfer_req=0 next cycle.
6. Busy protection and mid-op reset:
   - Write LEN=0x100 during RUN → LEN readback unchanged.
   - Assert rst_n=0 mid-RUN → xfer_req=0 and all registers 0 immediately.
